stack_ctrl: RTL and testbench

Sequencer for the 14-entry stack register file. It owns the stack pointer and accepts stack commands over a valid/ready handshake. It drives the register file's `op`, `we`, `sc` and `di` ports, and it reads back the register file's `do_a` (top of stack) and `do_b` (next on stack). It also expands SWAP into two register-file writes and flags overflow, underflow and illegal commands with a sticky fault that blocks further commands until cleared.

---
 rtl/definitions.sv | 27 ++
 rtl/stack_chk.sv | 77 +++++++
 rtl/stack_ctrl.sv | 156 +++++++++++++++
 tb/tb_stack_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared definitions for the stack sequencer: command codes, fault codes
// and the register-file operation encodings.
package definitions;

    // Register-file operation codes. DES_1 writes core[sc-2] (collapse the top
    // two entries into one), ADV_1 writes core[sc] (grow the stack by one).
    localparam logic [1:0] RF_NOP = 2'd0;
    localparam logic [1:0] DES_1  = 2'd1;
    localparam logic [1:0] ADV_1  = 2'd2;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        BIN  = 3'd3,
        DUP  = 3'd4,
        SWAP = 3'd5
    } stack_cmd_t;

    typedef enum logic [1:0] {
        FLT_NONE = 2'd0,
        FLT_OVF  = 2'd1,
        FLT_UNF  = 2'd2,
        FLT_ILL  = 2'd3
    } fault_t;

endpackage

// File: rtl/stack_chk.sv
// Command legality checker: decides whether a command is allowed at the
// current stack depth, which fault it raises if not, and the resulting depth.
module stack_chk
    import definitions::*;
#(
    parameter int DEPTH = 14,
    parameter int SPW   = 4
) (
    input  logic [2:0]     cmd,
    input  logic [SPW-1:0] sp,
    output logic           legal,
    output fault_t         fault_code,
    output logic [SPW-1:0] sp_next
);

    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO   = SPW'(2);
    localparam logic [SPW-1:0] SP_DEPTH = SPW'(DEPTH);

    // Precondition table per command; a failing command leaves the depth alone.
    always_comb begin
        legal      = 1'b1;
        fault_code = FLT_NONE;
        sp_next    = sp;
        case (stack_cmd_t'(cmd))
            NOP: begin
                sp_next = sp;
            end
            PUSH: begin
                if (sp < SP_DEPTH) begin
                    sp_next = sp + SP_ONE;
                end else begin
                    legal      = 1'b0;
                    fault_code = FLT_OVF;
                end
            end
            POP: begin
                if (sp >= SP_ONE) begin
                    sp_next = sp - SP_ONE;
                end else begin
                    legal      = 1'b0;
                    fault_code = FLT_UNF;
                end
            end
            BIN: begin
                if (sp >= SP_TWO) begin
                    sp_next = sp - SP_ONE;
                end else begin
                    legal      = 1'b0;
                    fault_code = FLT_UNF;
                end
            end
            DUP: begin
                if (sp < SP_ONE) begin
                    legal      = 1'b0;
                    fault_code = FLT_UNF;
                end else if (sp >= SP_DEPTH) begin
                    legal      = 1'b0;
                    fault_code = FLT_OVF;
                end else begin
                    sp_next = sp + SP_ONE;
                end
            end
            SWAP: begin
                if (sp < SP_TWO) begin
                    legal      = 1'b0;
                    fault_code = FLT_UNF;
                end
            end
            default: begin
                legal      = 1'b0;
                fault_code = FLT_ILL;
            end
        endcase
    end

endmodule

// File: rtl/stack_ctrl.sv
// Stack sequencer: owns the stack pointer, accepts commands over a
// valid/ready handshake and drives the stack register file. SWAP is split
// into two register-file writes; illegal commands park the block in a sticky
// fault state until fault_clr.
module stack_ctrl
    import definitions::*;
#(
    parameter int DEPTH = 14,
    parameter int DW    = 8,
    parameter int SPW   = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd,
    input  logic [DW-1:0]  cmd_data,
    input  logic           fault_clr,
    output logic [1:0]     rf_op,
    output logic           rf_we,
    output logic [SPW-1:0] rf_sc,
    output logic [DW-1:0]  rf_di,
    input  logic [DW-1:0]  rf_do_a,
    input  logic [DW-1:0]  rf_do_b,
    output logic [SPW-1:0] sp,
    output logic           fault,
    output logic [1:0]     fault_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP2 = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [SPW-1:0] SP_ONE = SPW'(1);

    state_t         state;
    logic [DW-1:0]  hold_b;
    fault_t         fault_q;

    logic           chk_legal;
    fault_t         chk_code;
    logic [SPW-1:0] chk_sp_next;

    stack_chk #(
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_chk (
        .cmd        (cmd),
        .sp         (sp),
        .legal      (chk_legal),
        .fault_code (chk_code),
        .sp_next    (chk_sp_next)
    );

    assign fault_code = fault_q;
    assign fault      = reset_n && (fault_q != FLT_NONE);

    // Register-file drive and handshake; everything is held quiet during reset
    // so a reset landing on SWAP2 cancels the second write.
    always_comb begin
        cmd_ready = 1'b0;
        rf_we     = 1'b0;
        rf_op     = RF_NOP;
        rf_sc     = '0;
        rf_di     = '0;
        if (reset_n) begin
            case (state)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    rf_sc     = sp;
                    if (cmd_valid && chk_legal) begin
                        case (stack_cmd_t'(cmd))
                            PUSH: begin
                                rf_we = 1'b1;
                                rf_op = ADV_1;
                                rf_di = cmd_data;
                            end
                            BIN: begin
                                rf_we = 1'b1;
                                rf_op = DES_1;
                                rf_di = cmd_data;
                            end
                            DUP: begin
                                rf_we = 1'b1;
                                rf_op = ADV_1;
                                rf_di = rf_do_a;
                            end
                            SWAP: begin
                                rf_we = 1'b1;
                                rf_op = DES_1;
                                rf_di = rf_do_a;
                            end
                            default: begin
                                rf_we = 1'b0;
                            end
                        endcase
                    end
                end
                ST_SWAP2: begin
                    rf_sc = sp - SP_ONE;
                    rf_we = 1'b1;
                    rf_op = ADV_1;
                    rf_di = hold_b;
                end
                ST_FAULT: begin
                    rf_sc = sp;
                end
                default: begin
                    rf_sc = sp;
                end
            endcase
        end
    end

    // Sequencer state, stack pointer, SWAP holding register and sticky fault.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sp      <= '0;
            hold_b  <= '0;
            fault_q <= FLT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (chk_legal) begin
                            sp <= chk_sp_next;
                            if (stack_cmd_t'(cmd) == SWAP) begin
                                hold_b <= rf_do_b;
                                state  <= ST_SWAP2;
                            end
                        end else begin
                            fault_q <= chk_code;
                            state   <= ST_FAULT;
                        end
                    end
                end
                ST_SWAP2: begin
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_q <= FLT_NONE;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a register-file model closes the loop, a queue-based
// stack model predicts each command, and a monitor scores the DUT's response.
module tb_stack_ctrl;
    import definitions::*;

    localparam int DEPTH = 14;
    localparam int DW    = 8;
    localparam int SPW   = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [2:0]     cmd = 3'd0;
    logic [DW-1:0]  cmd_data = '0;
    logic           fault_clr = 1'b0;
    logic           cmd_ready;
    logic [1:0]     rf_op;
    logic           rf_we;
    logic [SPW-1:0] rf_sc;
    logic [DW-1:0]  rf_di;
    logic [DW-1:0]  rf_do_a;
    logic [DW-1:0]  rf_do_b;
    logic [SPW-1:0] sp;
    logic           fault;
    logic [1:0]     fault_code;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic         we;
        logic [7:0]   di;
        logic [1:0]   cycles;
        logic [3:0]   sp;
        logic         flt;
        logic [1:0]   code;
        logic [127:0] img;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_q[$];
    logic [7:0] core [16];

    always #5 clk = ~clk;

    stack_ctrl #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .SPW   (SPW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_data   (cmd_data),
        .fault_clr  (fault_clr),
        .rf_op      (rf_op),
        .rf_we      (rf_we),
        .rf_sc      (rf_sc),
        .rf_di      (rf_di),
        .rf_do_a    (rf_do_a),
        .rf_do_b    (rf_do_b),
        .sp         (sp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    // Register-file model: reads top/next below sc, ADV_1 writes at sc, DES_1 at sc-2.
    assign rf_do_a = core[rf_sc - 4'd1];
    assign rf_do_b = core[rf_sc - 4'd2];

    always @(posedge clk) begin
        if (rf_we) begin
            if (rf_op == ADV_1) core[rf_sc] <= rf_di;
            else if (rf_op == DES_1) core[rf_sc - 4'd2] <= rf_di;
        end
    end

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_ref();
        logic [127:0] img;
        img = '0;
        for (int i = 0; i < ref_q.size(); i++) img[i*8 +: 8] = ref_q[i];
        return img;
    endfunction

    function automatic logic [127:0] pack_core(input logic [3:0] n);
        logic [127:0] img;
        img = '0;
        for (int i = 0; i < int'(n); i++) img[i*8 +: 8] = core[i];
        return img;
    endfunction

    // Predict the command on the abstract stack, queue the expectation, then drive it until accepted.
    task automatic apply_stimulus(input logic [2:0] c, input logic [7:0] d, input logic clr);
        exp_t       e;
        int         n;
        int         guard;
        logic [7:0] t;
        n = ref_q.size();
        e = '0;
        e.cycles = 2'd1;
        case (c)
            3'd0: ;
            3'd1: begin
                if (n < DEPTH) begin
                    e.we = 1'b1; e.di = d; ref_q.push_back(d);
                end else begin
                    e.flt = 1'b1; e.code = FLT_OVF;
                end
            end
            3'd2: begin
                if (n >= 1) void'(ref_q.pop_back());
                else begin e.flt = 1'b1; e.code = FLT_UNF; end
            end
            3'd3: begin
                if (n >= 2) begin
                    e.we = 1'b1; e.di = d;
                    void'(ref_q.pop_back());
                    void'(ref_q.pop_back());
                    ref_q.push_back(d);
                end else begin
                    e.flt = 1'b1; e.code = FLT_UNF;
                end
            end
            3'd4: begin
                if (n == 0) begin
                    e.flt = 1'b1; e.code = FLT_UNF;
                end else if (n >= DEPTH) begin
                    e.flt = 1'b1; e.code = FLT_OVF;
                end else begin
                    e.we = 1'b1; e.di = ref_q[n-1]; ref_q.push_back(ref_q[n-1]);
                end
            end
            3'd5: begin
                if (n >= 2) begin
                    e.we = 1'b1; e.di = ref_q[n-1]; e.cycles = 2'd2;
                    t = ref_q[n-1]; ref_q[n-1] = ref_q[n-2]; ref_q[n-2] = t;
                end else begin
                    e.flt = 1'b1; e.code = FLT_UNF;
                end
            end
            default: begin
                e.flt = 1'b1; e.code = FLT_ILL;
            end
        endcase
        e.sp  = 4'(ref_q.size());
        e.img = pack_ref();
        sb.push_back(e);

        cmd_valid = 1'b1; cmd = c; cmd_data = d; fault_clr = clr;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cmd_ready && guard < 8);
        if (!cmd_ready) begin
            checks++; failures++;
            $display("[TB] FAIL accept_timeout actual=cmd_ready_low expected=accept_within_8_cycles");
            finish_run();
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; fault_clr = 1'b0;
        if (e.flt) begin
            cmd_valid = 1'b1; cmd = 3'($urandom_range(0, 7)); cmd_data = 8'($urandom);
            @(posedge clk); #1;
            cmd_valid = 1'b0; fault_clr = 1'b1;
            @(posedge clk); #1;
            fault_clr = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: scores accept-cycle writes, post-command state, fault hold/clear and reset outputs.
    initial begin : monitor
        exp_t cur;
        int   wait_cnt;
        bit   in_fault;
        bit   clr_pending;
        bit   was_reset;
        cur = '0; wait_cnt = 0; in_fault = 0; clr_pending = 0; was_reset = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check_output("reset_outputs", 128'({cmd_ready, rf_we, rf_op, rf_sc, rf_di, fault}), 128'(0));
                wait_cnt = 0; in_fault = 0; clr_pending = 0; was_reset = 1;
                sb.delete();
            end else begin
                if (was_reset) begin
                    check_output("post_reset_state", 128'({sp, fault, fault_code, cmd_ready}), 128'({4'd0, 1'b0, 2'd0, 1'b1}));
                    was_reset = 0;
                end
                if (clr_pending) begin
                    check_output("fault_cleared", 128'({fault, fault_code, cmd_ready}), 128'({1'b0, 2'd0, 1'b1}));
                    clr_pending = 0;
                end
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt > 0) begin
                        check_output("swap2_busy", 128'({cmd_ready, fault}), 128'(0));
                    end else begin
                        check_output("sp", 128'(sp), 128'(cur.sp));
                        check_output("fault_flags", 128'({fault, fault_code}), 128'({cur.flt, cur.code}));
                        check_output("ready_after", 128'(cmd_ready), 128'(!cur.flt));
                        check_output("stack_contents", pack_core(cur.sp), cur.img);
                        in_fault = cur.flt;
                    end
                end else if (in_fault) begin
                    check_output("fault_hold", 128'({fault, cmd_ready, rf_we}), 128'({1'b1, 1'b0, 1'b0}));
                end
                if (in_fault && fault_clr) begin
                    in_fault = 0;
                    clr_pending = 1;
                end
                if (cmd_valid && cmd_ready) begin
                    if (sb.size() == 0) begin
                        check_output("unexpected_accept", 128'(1), 128'(0));
                    end else begin
                        cur = sb.pop_front();
                        check_output("accept_we", 128'(rf_we), 128'(cur.we));
                        if (cur.we) check_output("accept_di", 128'(rf_di), 128'(cur.di));
                        else check_output("accept_quiet", 128'({rf_op, rf_di}), 128'(0));
                        wait_cnt = int'(cur.cycles);
                    end
                end else if (!cmd_valid && cmd_ready) begin
                    check_output("idle_no_write", 128'({rf_we, rf_op, rf_di}), 128'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        checks++; failures++;
        $display("[TB] FAIL watchdog actual=still_running expected=finished");
        finish_run();
    end

    // Directed test-plan scenarios, then a randomized run, then reset during SWAP2.
    initial begin : stimulus
        logic [2:0] c;
        int         r;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] push pair, BIN, DUP");
        apply_stimulus(3'd1, 8'h11, 1'b0);
        apply_stimulus(3'd1, 8'h22, 1'b0);
        check_output("top_next_after_push", 128'({rf_do_a, rf_do_b}), 128'({8'h22, 8'h11}));
        apply_stimulus(3'd3, 8'h33, 1'b0);
        apply_stimulus(3'd4, 8'h00, 1'b0);

        $display("[TB] swap");
        apply_stimulus(3'd2, 8'h00, 1'b0);
        apply_stimulus(3'd2, 8'h00, 1'b0);
        apply_stimulus(3'd1, 8'h11, 1'b0);
        apply_stimulus(3'd1, 8'h22, 1'b0);
        apply_stimulus(3'd5, 8'h00, 1'b0);
        idle_cycles(1);
        check_output("top_next_after_swap", 128'({rf_do_a, rf_do_b, sp}), 128'({8'h11, 8'h22, 4'd2}));

        $display("[TB] overflow");
        while (ref_q.size() < DEPTH) apply_stimulus(3'd1, 8'($urandom), 1'b0);
        apply_stimulus(3'd1, 8'h99, 1'b0);
        apply_stimulus(3'd2, 8'h00, 1'b0);

        $display("[TB] underflow and illegal");
        while (ref_q.size() > 0) apply_stimulus(3'd2, 8'h00, 1'b0);
        apply_stimulus(3'd2, 8'h00, 1'b0);
        apply_stimulus(3'd7, 8'h5a, 1'b0);
        apply_stimulus(3'd6, 8'ha5, 1'b0);
        apply_stimulus(3'd4, 8'h00, 1'b0);
        apply_stimulus(3'd5, 8'h00, 1'b0);

        $display("[TB] random commands");
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 15);
            if (r < 6) c = 3'd1;
            else if (r < 8 || r == 13) c = 3'd2;
            else if (r == 8 || r == 15) c = 3'd3;
            else if (r == 9) c = 3'd4;
            else if (r < 12) c = 3'd5;
            else if (r == 12) c = 3'd0;
            else c = 3'($urandom_range(6, 7));
            if ($urandom_range(0, 9) == 0) idle_cycles(1);
            apply_stimulus(c, 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] reset during swap");
        while (ref_q.size() > 0) apply_stimulus(3'd2, 8'h00, 1'b0);
        apply_stimulus(3'd1, 8'h44, 1'b0);
        apply_stimulus(3'd1, 8'h55, 1'b0);
        apply_stimulus(3'd5, 8'h00, 1'b0);
        reset_n = 1'b0;
        cmd_valid = 1'b1; cmd = 3'd1; cmd_data = 8'h77;
        @(posedge clk); #1;
        check_output("half_swap", 128'({core[0], core[1]}), 128'({8'h55, 8'h55}));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ref_q.delete();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) apply_stimulus(3'($urandom_range(0, 5)), 8'($urandom), 1'b0);

        idle_cycles(4);
        check_output("scoreboard_drained", 128'(sb.size()), 128'(0));
        finish_run();
    end

endmodule
